// File: rtl/uart_rx_fifo.sv
// RX byte buffer, DEPTH=2**PTR_WIDTH, FWFT head visible the cycle after push; in_ready=!full, sticky overrun.
// Optional synchronous flush port when UART_RX_FIFO_FLUSH_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overrun,
  input  logic                  clr_overrun
`ifdef UART_RX_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0]   DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE   = (PTR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  do_flush;

`ifdef UART_RX_FIFO_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;
  // Gate the head with empty so stale memory never shows and reset clears it immediately.
  assign out_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so an overrun occurring during the clear pulse is not lost.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      overrun <= 1'b0;
    end else if (in_valid && full) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model, directed scenarios plus random traffic.
module tb_uart_rx_fifo;

  logic       pclk;
  logic       prstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       overrun;
  logic       clr_overrun;
  logic       flush;

  int total;
  int bad;

  logic [7:0] q[$];
  logic       m_ovr;

  uart_rx_fifo #(.DATA_WIDTH(8), .PTR_WIDTH(4)) dut (
    .pclk        (pclk),
    .prstn       (prstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
`ifdef UART_RX_FIFO_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Drive one cycle of inputs just after a falling edge, advance the model across the
  // rising edge, and return at the next falling edge where outputs are sampled.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c,
                      input logic f);
    logic do_push;
    logic do_pop;
    in_valid    = v;
    in_data     = d;
    out_ready   = r;
    clr_overrun = c;
    flush       = f;
    do_push = v && (q.size() < 16);
    do_pop  = r && (q.size() > 0);
    if (v && q.size() == 16) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
`ifdef UART_RX_FIFO_FLUSH_EN
    if (f) begin
      q.delete();
      do_push = 1'b0;
      do_pop  = 1'b0;
    end
`endif
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    @(negedge pclk);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    prstn = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    @(negedge pclk);
    prstn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_single_push();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    total++; if (level !== 5'd16) begin bad++; $display("FAIL fill_level got=%0d exp=16", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    // Push offered with pop while full must not write through.
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    total++; if (level !== 5'd15) begin bad++; $display("FAIL full_nowt_level got=%0d exp=15", level); end
    for (int i = 1; i < 16; i++) begin
      total++;
      if (out_data !== 8'(i) || out_valid !== 1'b1) begin
        bad++; $display("FAIL drain_order[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total++; if (out_valid !== 1'b0 || level !== 5'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, level); end
    // Pop on empty must be ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    total++; if (out_data !== 8'h3C || level !== 5'd1) begin bad++; $display("FAIL empty_pop got=%h/%0d exp=3c/1", out_data, level); end
    do_reset();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL ovr_level got=%0d exp=16", level); end
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (overrun !== 1'b1 || level !== 5'd15) begin bad++; $display("FAIL ovr_sticky got=%b/%0d exp=1/15", overrun, level); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (out_data !== q[0]) begin bad++; $display("FAIL ovr_data[%0d] got=%h exp=%h", i, out_data, q[0]); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] exp_d;
      exp_d = q[0];
      step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      total++;
      if (level !== 5'd5 || out_data !== q[0]) begin
        bad++; $display("FAIL b2b[%0d] level=%0d data=%h exp level=5 data=%h (prev head %h)", i, level, out_data, q[0], exp_d);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (level !== 5'd7 || overrun !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0d/%b exp=7/1", level, overrun); end
    #2;
    prstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL arst_overrun got=%b exp=0", overrun); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", out_data); end
    q.delete();
    m_ovr = 1'b0;
    @(negedge pclk);
    prstn = 1'b1;
    @(negedge pclk);
  endtask

`ifdef UART_RX_FIFO_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    total++; if (level !== 5'd9) begin bad++; $display("FAIL flush_pre got=%0d exp=9", level); end
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    total++; if (level !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%b exp=0/0", level, out_valid); end
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    total++; if (out_data !== 8'h12 || level !== 5'd1) begin bad++; $display("FAIL flush_drop got=%h/%0d exp=12/1", out_data, level); end
    do_reset();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic       r;
      logic       c;
      logic [7:0] exp_d;
      // Bias phases so the FIFO spends time both near full and near empty.
      v = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 80 : 30));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80));
      c = ($urandom_range(0, 9) == 0);
      step(v, 8'($urandom), r, c, 1'b0);
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
      total++;
      if (level !== 5'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < 16) ||
          out_data !== exp_d || overrun !== m_ovr) begin
        bad++;
        $display("FAIL rand[%0d] lvl=%0d vld=%b rdy=%b dat=%h ovr=%b exp lvl=%0d dat=%h ovr=%b",
                 i, level, out_valid, in_ready, out_data, overrun, q.size(), exp_d, m_ovr);
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    prstn       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    flush       = 1'b0;
    m_ovr       = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overrun();
    test_back_to_back();
    test_async_reset();
`ifdef UART_RX_FIFO_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
